alu_exec_unit: RTL and testbench

- Execute stage directly downstream of the register-file read ports: consumes the left/right operands and destination address, computes the result, and drives the register-file write port (we, dest_addr, result).
- Single-cycle logic/arithmetic/shift ops; an iterative multi-cycle multiply occupies the unit and back-pressures issue.
- Sits between operand fetch and register write-back; the write-back fields connect straight to the register file.

---
 rtl/exec_defs_pkg.sv | 26 ++
 rtl/seq_mul.sv | 63 ++++++
 rtl/alu_exec_unit.sv | 152 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/exec_defs_pkg.sv
// Shared definitions for the execute stage: opcode map, FSM states and
// default widths.
package exec_defs_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_SRA = 4'd8,
    OP_MUL = 4'd9
  } opcode_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_W cycles.
// done/product are combinational on the cycle whose edge completes the last bit.
module seq_mul #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // product already includes the current bit, so the last iteration's sum
  // can be written back on the same edge that completes it.
  always_comb begin
    product = acc_q + (mplier_q[0] ? mcand_q : '0);
    done    = run && (cnt_q == LAST);
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
    end else if (run) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU plus optional iterative multiply, driving
// the register-file write port. Macro ALU_EXEC_MUL_EN builds the multiplier.
module alu_exec_unit
  import exec_defs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic [ADDR_W-1:0] dest_in,
  output logic              we,
  output logic [ADDR_W-1:0] dest_addr,
  output logic [DATA_W-1:0] result,
  output logic              illegal_op
);

  logic [DATA_W-1:0] alu_res;
  logic [4:0]        shamt;
  logic              single_op;
  logic              issue_fire;

  logic              we_q, we_d;
  logic              ill_q, ill_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [ADDR_W-1:0] dest_q, dest_d;

  always_comb begin
    shamt     = right_in[4:0];
    alu_res   = '0;
    single_op = 1'b1;
    case (op)
      OP_ADD:  alu_res = left_in + right_in;
      OP_SUB:  alu_res = left_in - right_in;
      OP_AND:  alu_res = left_in & right_in;
      OP_OR:   alu_res = left_in | right_in;
      OP_XOR:  alu_res = left_in ^ right_in;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(left_in) < $signed(right_in)};
      OP_SLL:  alu_res = left_in << shamt;
      OP_SRL:  alu_res = left_in >> shamt;
      OP_SRA:  alu_res = $signed(left_in) >>> shamt;
      default: single_op = 1'b0;
    endcase
  end

  always_comb issue_fire = issue_valid && issue_ready;

`ifdef ALU_EXEC_MUL_EN
  state_t            state_q, state_d;
  logic              mul_start, mul_run, mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [ADDR_W-1:0] mul_dest_q, mul_dest_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mul_dest_q <= '0;
    end else begin
      state_q    <= state_d;
      mul_dest_q <= mul_dest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (issue_fire && op == OP_MUL) state_d = ST_MUL_RUN;
      ST_MUL_RUN: if (mul_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_ready = (state_q == ST_IDLE);
    mul_run     = (state_q == ST_MUL_RUN);
    mul_start   = issue_fire && (op == OP_MUL);
  end

  seq_mul #(.DATA_W(DATA_W)) u_seq_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .run     (mul_run),
    .a       (left_in),
    .b       (right_in),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  always_comb issue_ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      ill_q    <= 1'b0;
      result_q <= '0;
      dest_q   <= '0;
    end else begin
      we_q     <= we_d;
      ill_q    <= ill_d;
      result_q <= result_d;
      dest_q   <= dest_d;
    end
  end

  // Without the multiplier, op 9 falls through to the illegal branch.
  always_comb begin
    we_d     = 1'b0;
    ill_d    = 1'b0;
    result_d = result_q;
    dest_d   = dest_q;
`ifdef ALU_EXEC_MUL_EN
    mul_dest_d = mul_dest_q;
`endif
    if (issue_fire) begin
      if (single_op) begin
        we_d     = 1'b1;
        result_d = alu_res;
        dest_d   = dest_in;
      end
`ifdef ALU_EXEC_MUL_EN
      else if (op == OP_MUL) begin
        mul_dest_d = dest_in;
      end
`endif
      else begin
        ill_d = 1'b1;
      end
    end
`ifdef ALU_EXEC_MUL_EN
    if (mul_done) begin
      we_d     = 1'b1;
      result_d = mul_product;
      dest_d   = mul_dest_q;
    end
`endif
  end

  always_comb begin
    we         = we_q;
    illegal_op = ill_q;
    result     = result_q;
    dest_addr  = dest_q;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; multiply scenarios are
// exercised when ALU_EXEC_MUL_EN is defined, op 9 as illegal otherwise.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  op;
  logic [31:0] left_in;
  logic [31:0] right_in;
  logic [4:0]  dest_in;
  logic        we;
  logic [4:0]  dest_addr;
  logic [31:0] result;
  logic        illegal_op;

  int unsigned errors = 0;
  int unsigned checks = 0;

  alu_exec_unit #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .op          (op),
    .left_in     (left_in),
    .right_in    (right_in),
    .dest_in     (dest_in),
    .we          (we),
    .dest_addr   (dest_addr),
    .result      (result),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] l,
                       input logic [31:0] r, input logic [4:0] d);
    issue_valid = v;
    op          = o;
    left_in     = l;
    right_in    = r;
    dest_in     = d;
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] res, input logic [4:0] d);
    chk({tag, "_we"}, {31'd0, we}, 32'd1);
    chk({tag, "_res"}, result, res);
    chk({tag, "_dest"}, {27'd0, dest_addr}, {27'd0, d});
  endtask

  initial begin
    int unsigned wait_n;
    logic        seen_we;
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    cyc();
    cyc();
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_ill", {31'd0, illegal_op}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_dest", {27'd0, dest_addr}, 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("rel_ready", {31'd0, issue_ready}, 32'd1);

    drive(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 5'd3);
    cyc();
    chk_wb("add_wrap", 32'h0000_0000, 5'd3);
    chk("add_ill", {31'd0, illegal_op}, 32'd0);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    cyc();
    chk("idle_we", {31'd0, we}, 32'd0);
    chk("idle_hold_dest", {27'd0, dest_addr}, 32'd3);

    drive(1'b1, 4'd1, 32'd0, 32'd1, 5'd4);
    cyc();
    chk_wb("sub", 32'hFFFF_FFFF, 5'd4);
    drive(1'b1, 4'd5, 32'hFFFF_FFFF, 32'd1, 5'd5);
    cyc();
    chk_wb("slt_neg", 32'd1, 5'd5);
    drive(1'b1, 4'd5, 32'd1, 32'hFFFF_FFFF, 5'd6);
    cyc();
    chk_wb("slt_pos", 32'd0, 5'd6);
    drive(1'b1, 4'd8, 32'h8000_0000, 32'h0000_0024, 5'd10);
    cyc();
    chk_wb("sra", 32'hF800_0000, 5'd10);
    drive(1'b1, 4'd7, 32'h8000_0000, 32'h0000_0024, 5'd11);
    cyc();
    chk_wb("srl", 32'h0800_0000, 5'd11);
    drive(1'b1, 4'd6, 32'd1, 32'd31, 5'd12);
    cyc();
    chk_wb("sll", 32'h8000_0000, 5'd12);
    drive(1'b1, 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    cyc();
    chk_wb("and_r0", 32'h00F0_00F0, 5'd0);

    drive(1'b1, 4'd0, 32'd5, 32'd6, 5'd1);
    cyc();
    chk_wb("b2b_add", 32'h0000_000B, 5'd1);
    drive(1'b1, 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 5'd2);
    cyc();
    chk_wb("b2b_xor", 32'h5555_5555, 5'd2);
    drive(1'b1, 4'd3, 32'h0000_0F00, 32'h0000_00F0, 5'd9);
    cyc();
    chk_wb("b2b_or", 32'h0000_0FF0, 5'd9);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    cyc();
    chk("b2b_end_we", {31'd0, we}, 32'd0);

    drive(1'b1, 4'd12, 32'd1, 32'd2, 5'd20);
    cyc();
    chk("ill12_pulse", {31'd0, illegal_op}, 32'd1);
    chk("ill12_we", {31'd0, we}, 32'd0);
    chk("ill12_res", result, 32'h0000_0FF0);
    chk("ill12_dest", {27'd0, dest_addr}, 32'd9);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    cyc();
    chk("ill12_end", {31'd0, illegal_op}, 32'd0);

`ifdef ALU_EXEC_MUL_EN
    drive(1'b1, 4'd9, 32'h0001_0001, 32'h0000_FFFF, 5'd7);
    cyc();
    chk("mul_e0_we", {31'd0, we}, 32'd0);
    chk("mul_e0_ready", {31'd0, issue_ready}, 32'd0);
    // Held request during the run must be ignored.
    drive(1'b1, 4'd0, 32'd2, 32'd3, 5'd8);
    for (int i = 1; i < 32; i++) begin
      cyc();
      chk("mul_run_ready", {31'd0, issue_ready}, 32'd0);
      chk("mul_run_we", {31'd0, we}, 32'd0);
    end
    cyc();
    chk_wb("mul_done", 32'hFFFF_FFFF, 5'd7);
    chk("mul_done_ready", {31'd0, issue_ready}, 32'd1);
    cyc();
    chk_wb("mul_next_add", 32'd5, 5'd8);

    drive(1'b1, 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13);
    cyc();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    wait_n = 0;
    do begin
      cyc();
      wait_n++;
    end while (!we && wait_n < 40);
    chk("mul2_latency", wait_n, 32'd32);
    chk_wb("mul2", 32'd1, 5'd13);

    drive(1'b1, 4'd9, 32'd3, 32'd4, 5'd14);
    cyc();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 10; i++) cyc();
    rst_n = 1'b0;
    #1;
    chk("abort_we", {31'd0, we}, 32'd0);
    chk("abort_res", result, 32'd0);
    chk("abort_ready", {31'd0, issue_ready}, 32'd1);
    cyc();
    rst_n = 1'b1;
    seen_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (we) seen_we = 1'b1;
    end
    chk("abort_no_write", {31'd0, seen_we}, 32'd0);
    chk("abort_dest", {27'd0, dest_addr}, 32'd0);
`else
    drive(1'b1, 4'd9, 32'd3, 32'd4, 5'd14);
    cyc();
    chk("mul_off_ill", {31'd0, illegal_op}, 32'd1);
    chk("mul_off_we", {31'd0, we}, 32'd0);
    chk("mul_off_res", result, 32'h0000_0FF0);
    chk("mul_off_ready", {31'd0, issue_ready}, 32'd1);
    drive(1'b1, 4'd1, 32'd10, 32'd3, 5'd15);
    cyc();
    chk_wb("mul_off_next", 32'd7, 5'd15);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_res", result, 32'd0);
    chk("midrun_rst_dest", {27'd0, dest_addr}, 32'd0);
    chk("midrun_rst_ready", {31'd0, issue_ready}, 32'd1);
    cyc();
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
